spi_sclk_engine: RTL and testbench

//  Second-generation SPI master clock/framing engine. Generates SCLK from sys_clk with any divider (odd included).

---
 rtl/spi_sclk_engine_pkg.sv | 19 +
 rtl/spi_half_period_cnt.sv | 41 ++++
 rtl/spi_sclk_engine.sv | 276 +++++++++++++++++++++++++++
 tb/tb_spi_sclk_engine.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sclk_engine_pkg.sv
// Shared definitions for the SPI SCLK/framing engine: FSM state encoding,
// default widths and a small helper.
package spi_sclk_engine_pkg;

    localparam int SPI_DIV_WIDTH = 16;
    localparam int SPI_CNT_WIDTH = 7;
    localparam int SPI_DLY_WIDTH = 8;
    localparam int SPI_NUM_CS    = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_half_period_cnt.sv
// Loadable down-counter shared by the SCLK half periods and the chip-select
// setup/hold delays. A phase loaded with n lasts exactly n cycles: tc is high
// in its last cycle, pre_tc in the cycle before that.
module spi_half_period_cnt
    import spi_sclk_engine_pkg::*;
#(
    parameter int W = SPI_DIV_WIDTH
) (
    input  logic         sys_clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc,
    output logic         pre_tc
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load takes priority; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc     = (cnt_q <= W'(1));
    assign pre_tc = (cnt_q == W'(2));

endmodule

// File: rtl/spi_sclk_engine.sv
// SPI master SCLK generator and character framing FSM.
// Optional macro SPI_CS_DELAY_EN: programmable chip-select setup/hold
// (cs_setup/cs_hold, 0 acts as 1). Without it both delays are one cycle.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no transfer; sclk tracks cpol, cs_n all high
// ST_SETUP | selected cs_n low, waiting before the first SCLK edge
// ST_RUN   | generating 2N edges plus a trailing half period at idle level
// ST_HOLD  | waiting before release; cs_n goes high in the last cycle
module spi_sclk_engine
    import spi_sclk_engine_pkg::*;
#(
    parameter  int DIV_WIDTH = SPI_DIV_WIDTH,
    parameter  int CNT_WIDTH = SPI_CNT_WIDTH,
    parameter  int NUM_CS    = SPI_NUM_CS,
    parameter  int DLY_WIDTH = SPI_DLY_WIDTH,
    localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [DIV_WIDTH-1:0] divider,
    input  logic [CNT_WIDTH-1:0] char_len,
    input  logic [CS_W-1:0]      cs_sel,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic [DLY_WIDTH-1:0] cs_setup,
    input  logic [DLY_WIDTH-1:0] cs_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 sclk,
    output logic [NUM_CS-1:0]    cs_n,
    output logic                 shift,
    output logic                 sample,
    output logic [CNT_WIDTH-1:0] bit_cnt
);

    localparam int CW = max_int(DIV_WIDTH, DLY_WIDTH);
    localparam int NW = CNT_WIDTH + 1;

    logic [1:0]           state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 sclk_q, sclk_d;
    logic [NUM_CS-1:0]    cs_n_q, cs_n_d;
    logic                 shift_q, shift_d;
    logic                 sample_q, sample_d;
    logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [NW-1:0]        nchar_q, nchar_d;
    logic [NW-1:0]        lead_cnt_q, lead_cnt_d;
    logic                 cpol_q, cpol_d;
    logic                 cpha_q, cpha_d;

    logic [DIV_WIDTH-1:0] div_in, half_lead, half_trail;
    logic [CW-1:0]        setup_len_in, hold_len;
    logic                 cnt_load, cnt_tc, cnt_pre_tc;
    logic [CW-1:0]        cnt_load_val;
    logic                 lead_edge, trail_edge;

    // Odd dividers put the extra cycle in the trailing half.
    assign div_in     = (divider < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : divider;
    assign half_lead  = div_q >> 1;
    assign half_trail = div_q - half_lead;

`ifdef SPI_CS_DELAY_EN
    logic [DLY_WIDTH-1:0] hold_q, hold_d;

    assign setup_len_in = (cs_setup == '0) ? CW'(1) : CW'(cs_setup);
    assign hold_len     = (hold_q == '0) ? CW'(1) : CW'(hold_q);

    // Capture the hold delay together with the rest of the configuration.
    always_comb begin
        hold_d = hold_q;
        if (state_q == ST_IDLE && start && !abort) begin
            hold_d = cs_hold;
        end
    end

    // Hold delay register.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    logic unused_dly;

    assign setup_len_in = CW'(1);
    assign hold_len     = CW'(1);
    assign unused_dly   = ^{cs_setup, cs_hold};
`endif

    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] m;
        m = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(sel) == i) begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    spi_half_period_cnt #(.W(CW)) u_hp_cnt (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .tc       (cnt_tc),
        .pre_tc   (cnt_pre_tc)
    );

    // Next-state, edge/strobe generation and abort override.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        sclk_d       = sclk_q;
        cs_n_d       = cs_n_q;
        shift_d      = 1'b0;
        sample_d     = 1'b0;
        bit_cnt_d    = bit_cnt_q;
        div_d        = div_q;
        nchar_d      = nchar_q;
        lead_cnt_d   = lead_cnt_q;
        cpol_d       = cpol_q;
        cpha_d       = cpha_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        lead_edge    = 1'b0;
        trail_edge   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sclk_d = cpol;
                busy_d = 1'b0;
                cs_n_d = '1;
                if (start && !abort) begin
                    state_d      = ST_SETUP;
                    busy_d       = 1'b1;
                    cs_n_d       = cs_decode(cs_sel);
                    bit_cnt_d    = '0;
                    lead_cnt_d   = '0;
                    div_d        = div_in;
                    nchar_d      = (char_len == '0) ? {1'b1, {CNT_WIDTH{1'b0}}}
                                                    : {1'b0, char_len};
                    cpol_d       = cpol;
                    cpha_d       = cpha;
                    cnt_load     = 1'b1;
                    cnt_load_val = setup_len_in;
                end
            end
            ST_SETUP: begin
                if (cnt_tc) begin
                    state_d   = ST_RUN;
                    lead_edge = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt_tc) begin
                    if (sclk_q != cpol_q) begin
                        trail_edge = 1'b1;
                    end else if (lead_cnt_q == nchar_q) begin
                        state_d      = ST_HOLD;
                        cnt_load     = 1'b1;
                        cnt_load_val = hold_len;
                        if (hold_len == CW'(1)) begin
                            cs_n_d = '1;
                        end
                    end else begin
                        lead_edge = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_tc) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cs_n_d  = '1;
                    sclk_d  = cpol_q;
                end else if (cnt_pre_tc) begin
                    cs_n_d = '1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (lead_edge) begin
            sclk_d       = ~cpol_q;
            lead_cnt_d   = lead_cnt_q + 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = CW'(half_lead);
            if (cpha_q) begin
                shift_d = 1'b1;
            end else begin
                sample_d  = 1'b1;
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        if (trail_edge) begin
            sclk_d       = cpol_q;
            cnt_load     = 1'b1;
            cnt_load_val = CW'(half_trail);
            if (cpha_q) begin
                sample_d  = 1'b1;
                bit_cnt_d = bit_cnt_q + 1'b1;
            end else begin
                // Bit 0 was preloaded, so the final trailing edge has nothing to shift.
                shift_d = (lead_cnt_q != nchar_q);
            end
        end

        if (abort && state_q != ST_IDLE) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            sclk_d    = cpol_q;
            cs_n_d    = '1;
            shift_d   = 1'b0;
            sample_d  = 1'b0;
            bit_cnt_d = bit_cnt_q;
            cnt_load  = 1'b0;
        end
    end

    // State, configuration and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sclk_q     <= cpol;
            cs_n_q     <= '1;
            shift_q    <= 1'b0;
            sample_q   <= 1'b0;
            bit_cnt_q  <= '0;
            div_q      <= DIV_WIDTH'(2);
            nchar_q    <= '0;
            lead_cnt_q <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            shift_q    <= shift_d;
            sample_q   <= sample_d;
            bit_cnt_q  <= bit_cnt_d;
            div_q      <= div_d;
            nchar_q    <= nchar_d;
            lead_cnt_q <= lead_cnt_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign shift   = shift_q;
    assign sample  = sample_q;
    assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Bench for spi_sclk_engine (three chip selects so an out-of-range select exists).
module tb_spi_sclk_engine;

    localparam int NCS = 3;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [15:0] divider = 16'd4;
    logic [6:0]  char_len = 7'd8;
    logic [1:0]  cs_sel = 2'd0;
    logic        cpol = 1'b1, cpha = 1'b0;
    logic [7:0]  cs_setup = 8'd0, cs_hold = 8'd0;
    logic        busy, done, sclk, shift, sample;
    logic [2:0]  cs_n;
    logic [6:0]  bit_cnt;

    spi_sclk_engine #(.NUM_CS(NCS)) dut (
        .sys_clk(sys_clk), .rst(rst), .start(start), .abort(abort),
        .divider(divider), .char_len(char_len), .cs_sel(cs_sel),
        .cpol(cpol), .cpha(cpha), .cs_setup(cs_setup), .cs_hold(cs_hold),
        .busy(busy), .done(done), .sclk(sclk), .cs_n(cs_n),
        .shift(shift), .sample(sample), .bit_cnt(bit_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0, n_fail = 0;

    // Model configuration: mode 0 = not checked, 1 = idle, 2 = transfer.
    int   m_mode = 0, m_k = 0, m_div = 0, m_len = 0, m_sel = 0, m_setup = 0, m_hold = 0;
    logic m_cpol = 1'b0, m_cpha = 1'b0, m_idle_sclk = 1'b0;
    int   m_bit_hold = 0;
    int   o_shift = 0, o_sample = 0, o_done = 0, o_first_edge = -1, o_cs_low = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (k=%0d, t=%0t)", name, act, exp, m_k, $time);
        end
    endtask

    function automatic int eff_s(input int setup);
`ifdef SPI_CS_DELAY_EN
        return (setup < 1) ? 1 : setup;
`else
        return 1;
`endif
    endfunction

    function automatic int eff_h(input int hold);
`ifdef SPI_CS_DELAY_EN
        return (hold < 1) ? 1 : hold;
`else
        return 1;
`endif
    endfunction

    function automatic int xfer_total(input int div, input int len, input int setup, input int hold);
        int d, n;
        d = (div < 2) ? 2 : div;
        n = (len == 0) ? 128 : len;
        return eff_s(setup) + n * d + eff_h(hold);
    endfunction

    // Compare process: expected outputs derived from the cycle index since start.
    always @(negedge sys_clk) begin : cmp
        int d, l, n, s, h, r, j, p, tot;
        logic eb, ed, es, esh, esa;
        logic [2:0] ecs, sel_mask;
        int ebc;
        if (m_mode != 0) begin
            eb = 0; ed = 0; es = m_idle_sclk; esh = 0; esa = 0; ecs = 3'b111; ebc = m_bit_hold;
            if (m_mode == 2) begin
                d = (m_div < 2) ? 2 : m_div;
                l = d / 2;
                n = (m_len == 0) ? 128 : m_len;
                s = eff_s(m_setup);
                h = eff_h(m_hold);
                tot = s + n * d + h;
                sel_mask = (m_sel < NCS) ? ~(3'b001 << m_sel) : 3'b111;
                es = m_cpol;
                if (m_k < s) begin
                    eb = 1; ecs = sel_mask; ebc = 0;
                end else if (m_k < s + n * d) begin
                    r = m_k - s; j = r / d; p = r % d;
                    eb = 1; ecs = sel_mask;
                    es = (p < l) ? ~m_cpol : m_cpol;
                    if (m_cpha) begin
                        esh = (p == 0);
                        esa = (p == l);
                        ebc = (j + ((p >= l) ? 1 : 0)) % 128;
                    end else begin
                        esa = (p == 0);
                        esh = (p == l) && (j < n - 1);
                        ebc = (j + 1) % 128;
                    end
                end else if (m_k < tot) begin
                    eb = 1; ebc = n % 128;
                    ecs = (m_k - s - n * d < h - 1) ? sel_mask : 3'b111;
                end else begin
                    ed = (m_k == tot); ebc = n % 128;
                end
            end
            chk("busy", busy, eb);
            chk("done", done, ed);
            chk("sclk", sclk, es);
            chk("cs_n", cs_n, ecs);
            chk("shift", shift, esh);
            chk("sample", sample, esa);
            chk("bit_cnt", bit_cnt, ebc);
            if (m_mode == 2) begin
                if (shift === 1'b1) o_shift++;
                if (sample === 1'b1) o_sample++;
                if (done === 1'b1) o_done++;
                if (cs_n !== 3'b111) o_cs_low++;
                if (o_first_edge < 0 && sclk !== m_cpol) o_first_edge = m_k;
                m_k++;
            end
        end
    end

    // kind: 0 normal, 1 abort (+start) after cycle k=at, 2 reset after k=at.
    task automatic do_xfer(input int div, input int len, input int sel, input logic pol,
                           input logic pha, input int setup, input int hold,
                           input int kind, input int at, input int hold_bits, input bit noise);
        int tot;
        @(posedge sys_clk); #1;
        divider = 16'(div); char_len = 7'(len); cs_sel = 2'(sel);
        cpol = pol; cpha = pha; cs_setup = 8'(setup); cs_hold = 8'(hold);
        start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        m_div = div; m_len = len; m_sel = sel; m_cpol = pol; m_cpha = pha;
        m_setup = setup; m_hold = hold; m_k = 0;
        o_shift = 0; o_sample = 0; o_done = 0; o_cs_low = 0; o_first_edge = -1;
        m_mode = 2;
        tot = xfer_total(div, len, setup, hold);
        if (kind != 0) begin
            repeat (at) @(posedge sys_clk);
            #1;
            if (kind == 1) begin
                abort = 1'b1; start = 1'b1;
            end else begin
                rst = 1'b1;
            end
            @(posedge sys_clk); #1;
            abort = 1'b0; start = 1'b0; rst = 1'b0;
            m_mode = 1; m_idle_sclk = pol; m_bit_hold = hold_bits;
            repeat (6) @(posedge sys_clk);
            #1;
        end else if (noise) begin
            @(posedge sys_clk); #1;
            start = 1'b1; divider = 16'd9; char_len = 7'd2; cs_sel = 2'd0;
            cpol = ~pol; cpha = ~pha;
            @(posedge sys_clk); #1;
            start = 1'b0; divider = 16'(div); char_len = 7'(len); cs_sel = 2'(sel);
            cpol = pol; cpha = pha;
            repeat (tot) @(posedge sys_clk);
            #1;
        end else begin
            repeat (tot + 2) @(posedge sys_clk);
            #1;
        end
        m_mode = 0;
    endtask

    initial begin
        // Reset with cpol=1: sclk must come up at the idle level.
        repeat (2) @(posedge sys_clk);
        #1;
        m_mode = 1; m_idle_sclk = 1'b1; m_bit_hold = 0;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("reset sclk", sclk, 1);
        chk("reset cs_n", cs_n, 3'b111);
        rst = 1'b0;
        @(posedge sys_clk); #1;
        cpol = 1'b0;
        @(posedge sys_clk); #1;
        m_idle_sclk = 1'b0;
        @(posedge sys_clk); #1;
        chk("idle sclk follows cpol", sclk, 0);
        m_mode = 0;

        // 1: div 4, len 8, mode 0.
        do_xfer(4, 8, 0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        chk("t1 samples", o_sample, 8);
        chk("t1 shifts", o_shift, 7);
        chk("t1 done count", o_done, 1);
        chk("t1 bit_cnt", bit_cnt, 8);
        chk("t1 first edge", o_first_edge, 1);

        // 2: odd divider, cpol=1, cpha=1.
        do_xfer(5, 3, 1, 1'b1, 1'b1, 0, 0, 0, 0, 0, 1'b0);
        chk("t2 shifts", o_shift, 3);
        chk("t2 samples", o_sample, 3);
        chk("t2 final sclk", sclk, 1);

        // 3: len 0 -> 128 bits, 256 edges, bit_cnt wraps.
        do_xfer(2, 0, 2, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        chk("t3 samples", o_sample, 128);
        chk("t3 done count", o_done, 1);
        chk("t3 bit_cnt", bit_cnt, 0);

        // 4: abort with simultaneous start after the third sample.
        do_xfer(4, 8, 0, 1'b0, 1'b0, 0, 0, 1, 9, 3, 1'b0);
        chk("t4 samples", o_sample, 3);
        chk("t4 done count", o_done, 0);
        chk("t4 busy after abort", busy, 0);

        // 5: chip-select setup/hold (ignored unless the delay macro is defined).
        do_xfer(6, 4, 0, 1'b0, 1'b1, 5, 3, 0, 0, 0, 1'b0);
`ifdef SPI_CS_DELAY_EN
        chk("t5 first edge", o_first_edge, 5);
`else
        chk("t5 first edge", o_first_edge, 1);
`endif
        do_xfer(3, 2, 1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        chk("t5 setup0 first edge", o_first_edge, 1);

        // 6: out-of-range select plus a start pulse while busy.
        do_xfer(4, 3, 3, 1'b0, 1'b1, 0, 0, 0, 0, 0, 1'b1);
        chk("t6 cs low cycles", o_cs_low, 0);
        chk("t6 samples", o_sample, 3);
        chk("t6 done count", o_done, 1);

        // Reset in the middle of a transfer.
        do_xfer(4, 8, 2, 1'b1, 1'b0, 0, 0, 2, 6, 0, 1'b0);

        // Divider below 2 behaves as 2; odd divider 7 with cpol=1.
        do_xfer(1, 2, 0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        chk("div1 samples", o_sample, 2);
        do_xfer(7, 5, 1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        chk("div7 shifts", o_shift, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
